mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port.
// One transaction in flight at a time, with a bounded wait that aborts and flags bus_error.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_mem_is_ready,
   input  logic [31:0] inst_mem_addr,
   output logic        inst_mem_is_valid,
   output logic [31:0] inst_mem_read_data,
   input  logic        data_mem_is_ready,
   input  logic [31:0] data_mem_addr,
   input  logic        data_mem_write,
   input  logic [31:0] data_mem_write_data,
   input  logic [3:0]  data_mem_byte_en,
   output logic        data_mem_is_valid,
   output logic [31:0] data_mem_read_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_byte_en,
   input  logic        mem_ack,
   input  logic [31:0] mem_read_data,
   output logic        bus_error
);

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;
   localparam int unsigned CW  = 8;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic GRANT_INST = 1'b0;
   localparam logic GRANT_DATA = 1'b1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t        state;
   state_t        state_next;
   logic          owner;
   logic          last_grant;
   logic [CW-1:0] wait_cnt;

   logic inst_elig;
   logic data_elig;
   logic grant_data;
   logic do_grant;
   logic do_done;
   logic do_abort;

   // A requester whose completion pulse is high this cycle still shows its old is_ready.
   assign inst_elig  = inst_mem_is_ready & ~inst_mem_is_valid;
   assign data_elig  = data_mem_is_ready & ~data_mem_is_valid;
   assign grant_data = data_elig & (~inst_elig | (last_grant == GRANT_INST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (inst_elig || data_elig) state_next = BUSY;
         BUSY:    if (mem_ack || (wait_cnt == CNT_LAST)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ack has priority over the timeout in the same cycle.
   always_comb begin
      do_grant = 1'b0;
      do_done  = 1'b0;
      do_abort = 1'b0;
      case (state)
         IDLE: do_grant = inst_elig | data_elig;
         BUSY: begin
            do_done  = mem_ack;
            do_abort = ~mem_ack & (wait_cnt == CNT_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner              <= GRANT_INST;
         last_grant         <= GRANT_DATA;
         wait_cnt           <= '0;
         mem_req            <= 1'b0;
         mem_addr           <= '0;
         mem_write          <= 1'b0;
         mem_write_data     <= '0;
         mem_byte_en        <= '0;
         inst_mem_is_valid  <= 1'b0;
         inst_mem_read_data <= '0;
         data_mem_is_valid  <= 1'b0;
         data_mem_read_data <= '0;
         bus_error          <= 1'b0;
      end else begin
         inst_mem_is_valid <= 1'b0;
         data_mem_is_valid <= 1'b0;
         if (do_grant) begin
            owner      <= grant_data;
            last_grant <= grant_data;
            wait_cnt   <= '0;
            mem_req    <= 1'b1;
            if (grant_data) begin
               mem_addr       <= data_mem_addr;
               mem_write      <= data_mem_write;
               mem_write_data <= data_mem_write_data;
               mem_byte_en    <= data_mem_byte_en;
            end else begin
               mem_addr       <= AW'(inst_mem_addr);
               mem_write      <= 1'b0;
               mem_write_data <= '0;
               mem_byte_en    <= {BEW{1'b1}};
            end
         end
         if (do_done || do_abort) begin
            mem_req <= 1'b0;
            if (owner == GRANT_DATA) begin
               data_mem_is_valid  <= 1'b1;
               data_mem_read_data <= do_done ? mem_read_data : DW'(0);
            end else begin
               inst_mem_is_valid  <= 1'b1;
               inst_mem_read_data <= do_done ? mem_read_data : DW'(0);
            end
            if (do_abort) bus_error <= 1'b1;
         end else if (state == BUSY) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and memory model driven from queues,
// a negedge monitor checks every grant and completion against the expected queue.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int unsigned TO = 4;

   typedef struct {
      logic        side;
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          ack_cycle;
      logic [31:0] rdata;
   } tx_t;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dreq_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_mem_is_ready;
   logic [31:0] inst_mem_addr;
   logic        inst_mem_is_valid;
   logic [31:0] inst_mem_read_data;
   logic        data_mem_is_ready;
   logic [31:0] data_mem_addr;
   logic        data_mem_write;
   logic [31:0] data_mem_write_data;
   logic [3:0]  data_mem_byte_en;
   logic        data_mem_is_valid;
   logic [31:0] data_mem_read_data;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_write;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_en;
   logic        mem_ack;
   logic [31:0] mem_read_data;
   logic        bus_error;

   tx_t         exp_q[$];
   logic [31:0] inst_rq[$];
   dreq_t       data_rq[$];
   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   logic        force_ack = 1'b0;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk                 (clk),
      .reset               (reset),
      .inst_mem_is_ready   (inst_mem_is_ready),
      .inst_mem_addr       (inst_mem_addr),
      .inst_mem_is_valid   (inst_mem_is_valid),
      .inst_mem_read_data  (inst_mem_read_data),
      .data_mem_is_ready   (data_mem_is_ready),
      .data_mem_addr       (data_mem_addr),
      .data_mem_write      (data_mem_write),
      .data_mem_write_data (data_mem_write_data),
      .data_mem_byte_en    (data_mem_byte_en),
      .data_mem_is_valid   (data_mem_is_valid),
      .data_mem_read_data  (data_mem_read_data),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_write           (mem_write),
      .mem_write_data      (mem_write_data),
      .mem_byte_en         (mem_byte_en),
      .mem_ack             (mem_ack),
      .mem_read_data       (mem_read_data),
      .bus_error           (bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic issue_inst(input logic [31:0] a, input int ackc, input logic [31:0] rd);
      tx_t t;
      t.side = 1'b0; t.addr = a; t.write = 1'b0; t.wdata = 32'h0; t.be = 4'hF;
      t.ack_cycle = ackc; t.rdata = rd;
      exp_q.push_back(t);
      inst_rq.push_back(a);
   endtask

   task automatic issue_data(input logic [31:0] a, input logic w, input logic [31:0] wd,
                             input logic [3:0] be, input int ackc, input logic [31:0] rd);
      tx_t   t;
      dreq_t r;
      t.side = 1'b1; t.addr = a; t.write = w; t.wdata = wd; t.be = be;
      t.ack_cycle = ackc; t.rdata = rd;
      r.addr = a; r.write = w; r.wdata = wd; r.be = be;
      exp_q.push_back(t);
      data_rq.push_back(r);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int n);
      int k;
      k = 0;
      while (done_cnt < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("done_count", 32'(done_cnt), 32'(n));
      chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      sync();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'(0));
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_write"}, 32'(mem_write), 32'(0));
      chk({tag, "_mem_wdata"}, mem_write_data, 32'h0);
      chk({tag, "_mem_be"}, 32'(mem_byte_en), 32'(0));
      chk({tag, "_inst_valid"}, 32'(inst_mem_is_valid), 32'(0));
      chk({tag, "_data_valid"}, 32'(data_mem_is_valid), 32'(0));
      chk({tag, "_inst_rdata"}, inst_mem_read_data, 32'h0);
      chk({tag, "_data_rdata"}, data_mem_read_data, 32'h0);
      chk({tag, "_bus_error"}, 32'(bus_error), 32'(0));
   endtask

   // Instruction requester: holds is_ready until its completion pulse.
   initial begin
      inst_mem_is_ready = 1'b0;
      inst_mem_addr     = 32'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            inst_mem_is_ready = 1'b0;
            inst_rq.delete();
         end else begin
            if (inst_mem_is_valid) inst_mem_is_ready = 1'b0;
            if (!inst_mem_is_ready && inst_rq.size() > 0) begin
               inst_mem_addr     = inst_rq.pop_front();
               inst_mem_is_ready = 1'b1;
            end
         end
      end
   end

   // Data requester.
   initial begin
      dreq_t r;
      data_mem_is_ready   = 1'b0;
      data_mem_addr       = 32'h0;
      data_mem_write      = 1'b0;
      data_mem_write_data = 32'h0;
      data_mem_byte_en    = 4'h0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            data_mem_is_ready = 1'b0;
            data_rq.delete();
         end else begin
            if (data_mem_is_valid) data_mem_is_ready = 1'b0;
            if (!data_mem_is_ready && data_rq.size() > 0) begin
               r = data_rq.pop_front();
               data_mem_addr       = r.addr;
               data_mem_write      = r.write;
               data_mem_write_data = r.wdata;
               data_mem_byte_en    = r.be;
               data_mem_is_ready   = 1'b1;
            end
         end
      end
   end

   // Monitor and memory model: pops an expectation on each new mem_req, checks completions.
   initial begin
      tx_t  cur;
      tx_t  pend;
      logic active;
      logic pend_v;
      logic prev_req;
      int   busy;
      int   exp_len;
      active = 1'b0; pend_v = 1'b0; prev_req = 1'b0; busy = 0;
      mem_ack = 1'b0;
      mem_read_data = 32'hBADC0DE0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            active = 1'b0; pend_v = 1'b0; prev_req = 1'b0; busy = 0;
            mem_ack = force_ack;
            mem_read_data = 32'hFEEDFACE;
         end else begin
            if (mem_req && !prev_req) begin
               busy = 0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_grant", 32'(1), 32'(0));
                  active = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  active = 1'b1;
               end
            end
            if (mem_req) begin
               busy++;
               if (active) begin
                  chk("mem_addr", mem_addr, cur.addr);
                  chk("mem_write", 32'(mem_write), 32'(cur.write));
                  chk("mem_write_data", mem_write_data, cur.wdata);
                  chk("mem_byte_en", 32'(mem_byte_en), 32'(cur.be));
               end
            end
            if (!mem_req && prev_req && active) begin
               exp_len = (cur.ack_cycle == 0 || cur.ack_cycle > int'(TO)) ? int'(TO) : cur.ack_cycle;
               chk("mem_req_cycles", 32'(busy), 32'(exp_len));
               pend   = cur;
               pend_v = 1'b1;
               active = 1'b0;
            end
            if (inst_mem_is_valid || data_mem_is_valid) begin
               done_cnt++;
               chk("valid_exclusive", 32'(inst_mem_is_valid && data_mem_is_valid), 32'(0));
               if (!pend_v) begin
                  chk("spurious_valid", 32'(1), 32'(0));
               end else begin
                  chk("valid_side", 32'(data_mem_is_valid), 32'(pend.side));
                  chk("read_data", data_mem_is_valid ? data_mem_read_data : inst_mem_read_data,
                      (pend.ack_cycle == 0 || pend.ack_cycle > int'(TO)) ? 32'h0 : pend.rdata);
                  pend_v = 1'b0;
               end
            end
            mem_ack = (mem_req && active && busy == cur.ack_cycle) || force_ack;
            mem_read_data = mem_ack ? (active ? cur.rdata : 32'hFEEDFACE) : 32'hBADC0DE0;
            prev_req = mem_req;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int k;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 1'b1;
      sync();

      // Instruction-only fetch, acked on the 2nd busy cycle.
      issue_inst(32'h100, 2, 32'hDEADBEEF);
      wait_done(1);
      repeat (3) sync();
      chk("inst_rdata_hold", inst_mem_read_data, 32'hDEADBEEF);
      chk("bus_error_clean", 32'(bus_error), 32'(0));

      // Contended first grant after reset goes to instruction, then the store.
      do_reset();
      issue_inst(32'h0, 1, 32'h0000_1111);
      issue_data(32'h200, 1'b1, 32'h12345678, 4'h3, 2, 32'hCAFE_0200);
      wait_done(3);
      sync();
      chk("store_rdata", data_mem_read_data, 32'hCAFE_0200);

      // Both sides held requesting: alternation I,D,I,D,I,D.
      for (int i = 0; i < 3; i++) begin
         issue_inst(32'h1000 + 32'(i * 4), 1 + (i % 2), 32'h1100_0000 + 32'(i));
         issue_data(32'h2000 + 32'(i * 4), (i == 1), 32'hA000_0000 + 32'(i), 4'hF, 2,
                    32'h2200_0000 + 32'(i));
      end
      wait_done(9);
      sync();

      // Memory never acks: abort after TIMEOUT busy cycles, sticky error.
      issue_inst(32'h300, 0, 32'h0);
      wait_done(10);
      sync();
      chk("bus_error_set", 32'(bus_error), 32'(1));
      chk("timeout_rdata", inst_mem_read_data, 32'h0);
      issue_data(32'h304, 1'b0, 32'h0, 4'h0, 1, 32'h3333_0304);
      wait_done(11);
      sync();
      chk("bus_error_sticky", 32'(bus_error), 32'(1));

      // Ack on the last allowed cycle wins over the timeout.
      do_reset();
      chk("bus_error_cleared", 32'(bus_error), 32'(0));
      issue_data(32'h400, 1'b0, 32'h0, 4'hF, 4, 32'h4444_0400);
      wait_done(12);
      sync();
      chk("ack_at_limit_err", 32'(bus_error), 32'(0));

      // Reset in the 2nd busy cycle aborts without a pulse; late ack ignored.
      issue_inst(32'h500, 0, 32'h0);
      k = 0;
      while (!mem_req && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("abort_req_seen", 32'(mem_req), 32'(1));
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_all_zero("abort");
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      force_ack = 1'b1;
      repeat (2) sync();
      force_ack = 1'b0;
      repeat (3) sync();
      chk_all_zero("post_abort");
      chk("abort_no_pulse", 32'(done_cnt), 32'(12));
      chk("abort_q_empty", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
